// File: rtl/audio_codec_config.sv
// WM8731 configuration master: after reset it writes the 8-register setup
// table over I2C, then raises o_dac_enable to release the audio shifter.
// While idle it rewrites the headphone-volume register when i_volume moves.
module audio_codec_config #(
  parameter int         CLK_DIV  = 80,
  parameter logic [6:0] DEV_ADDR = 7'h1A,
  parameter int         RETRIES  = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_restart,
  input  logic [6:0] i_volume,
  input  logic       i_sda_in,
  output logic       o_scl,
  output logic       o_sda_oe,
  output logic       o_busy,
  output logic       o_dac_enable,
  output logic       o_ack_error
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam int RW = $clog2(RETRIES + 2);
  localparam logic [RW-1:0] RETRY_MAX = RW'(RETRIES);

  typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_STOP, S_GAP} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [DW-1:0] r_div;
  logic          w_tick;
  logic [2:0]    r_cnt;
  logic [1:0]    w_quarter;
  logic [4:0]    r_bitcnt;
  logic [2:0]    r_idx;
  logic [RW-1:0] r_retry;
  logic          r_single;
  logic          r_seq_pending;
  logic          r_nack;
  logic [6:0]    r_vol_q;
  logic          r_dac;
  logic          r_ack_err;
  logic          r_scl;
  logic          r_sda_oe;
  logic          w_scl_nxt;
  logic          w_sda_oe_nxt;
  logic [15:0]   w_word;
  logic [26:0]   w_frame;
  logic          w_bit;
  logic          w_ack_slot;
  logic          w_vol_change;
  logic          w_retry_same;

  assign w_tick       = (r_div == DIV_LAST);
  assign w_quarter    = r_cnt[1:0];
  assign w_vol_change = (i_volume != r_vol_q);
  assign w_retry_same = r_nack && (r_retry < RETRY_MAX);
  assign w_frame      = {DEV_ADDR, 1'b0, 1'b1, w_word[15:8], 1'b1, w_word[7:0], 1'b1};
  assign w_bit        = w_frame[5'd26 - r_bitcnt];
  assign w_ack_slot   = (r_bitcnt == 5'd8) || (r_bitcnt == 5'd17) || (r_bitcnt == 5'd26);

  assign o_scl        = r_scl;
  assign o_sda_oe     = r_sda_oe;
  assign o_busy       = (r_state != S_IDLE);
  assign o_dac_enable = r_dac;
  assign o_ack_error  = r_ack_err;

  // Register table: {reg[6:0], data[8:0]} for the current index
  always_comb begin
    w_word = 16'h0000;
    unique case (r_idx)
      3'd0: w_word = {7'd15, 9'h000};
      3'd1: w_word = {7'd6,  9'h007};
      3'd2: w_word = {7'd2,  2'b10, r_vol_q};
      3'd3: w_word = {7'd4,  9'h012};
      3'd4: w_word = {7'd5,  9'h000};
      3'd5: w_word = {7'd7,  9'h001};
      3'd6: w_word = {7'd8,  9'h000};
      3'd7: w_word = {7'd9,  9'h001};
      default: w_word = 16'h0000;
    endcase
  end

  // Quarter-bit prescaler producing the one-clock tick
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_div <= '0;
    else if (w_tick) r_div <= '0;
    else r_div <= r_div + DW'(1);
  end

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else r_state <= w_state_nxt;
  end

  // Next-state decode, evaluated only on ticks
  always_comb begin
    w_state_nxt = r_state;
    if (w_tick) begin
      unique case (r_state)
        S_IDLE:  if (r_seq_pending || w_vol_change) w_state_nxt = S_START;
        S_START: if (w_quarter == 2'd1) w_state_nxt = S_BIT;
        S_BIT:   if (w_quarter == 2'd3 && (r_bitcnt == 5'd26 || r_nack)) w_state_nxt = S_STOP;
        S_STOP:  if (w_quarter == 2'd2) w_state_nxt = S_GAP;
        S_GAP:   if (r_cnt == 3'd7)
                   w_state_nxt = (w_retry_same || (!r_single && r_idx != 3'd7)) ? S_START : S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Bus line targets for the coming tick
  always_comb begin
    w_scl_nxt    = r_scl;
    w_sda_oe_nxt = r_sda_oe;
    if (w_tick) begin
      unique case (r_state)
        S_START: begin
          if (w_quarter == 2'd0) w_sda_oe_nxt = 1'b1;
          else w_scl_nxt = 1'b0;
        end
        S_BIT: begin
          unique case (w_quarter)
            2'd0: begin
              w_scl_nxt    = 1'b0;
              w_sda_oe_nxt = w_ack_slot ? 1'b0 : ~w_bit;
            end
            2'd1: w_scl_nxt = 1'b1;
            2'd2: w_scl_nxt = 1'b1;
            2'd3: w_scl_nxt = 1'b0;
            default: w_scl_nxt = 1'b0;
          endcase
        end
        S_STOP: begin
          if (w_quarter == 2'd0) begin
            w_sda_oe_nxt = 1'b1;
            w_scl_nxt    = 1'b0;
          end else if (w_quarter == 2'd1) begin
            w_scl_nxt = 1'b1;
          end else if (w_quarter == 2'd2) begin
            w_sda_oe_nxt = 1'b0;
          end
        end
        default: begin
          w_scl_nxt    = 1'b1;
          w_sda_oe_nxt = 1'b0;
        end
      endcase
    end
  end

  // Phase counters, bus line registers, NACK capture and volume latch
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt    <= '0;
      r_bitcnt <= '0;
      r_nack   <= 1'b0;
      r_vol_q  <= '0;
      r_scl    <= 1'b1;
      r_sda_oe <= 1'b0;
    end else if (w_tick) begin
      r_scl    <= w_scl_nxt;
      r_sda_oe <= w_sda_oe_nxt;
      r_cnt    <= (w_state_nxt != r_state) ? 3'd0 : r_cnt + 3'd1;
      if (r_state != S_BIT) r_bitcnt <= '0;
      else if (w_quarter == 2'd3 && r_bitcnt != 5'd26) r_bitcnt <= r_bitcnt + 5'd1;
      if (r_state == S_START) r_nack <= 1'b0;
      else if (r_state == S_BIT && w_quarter == 2'd2 && w_ack_slot && i_sda_in) r_nack <= 1'b1;
      if (r_state == S_START && w_quarter == 2'd0) r_vol_q <= i_volume;
    end
  end

  // Sequence bookkeeping: register index, retries, completion and error flags
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_idx         <= '0;
      r_retry       <= '0;
      r_single      <= 1'b0;
      r_seq_pending <= 1'b1;
      r_dac         <= 1'b0;
      r_ack_err     <= 1'b0;
    end else begin
      if (r_state == S_IDLE && i_restart) r_seq_pending <= 1'b1;
      if (w_tick) begin
        unique case (r_state)
          S_IDLE: begin
            if (r_seq_pending) begin
              r_idx     <= 3'd0;
              r_single  <= 1'b0;
              r_retry   <= '0;
              r_dac     <= 1'b0;
              r_ack_err <= 1'b0;
            end else if (w_vol_change) begin
              r_idx    <= 3'd2;
              r_single <= 1'b1;
              r_retry  <= '0;
            end
          end
          S_GAP: begin
            if (r_cnt == 3'd7) begin
              if (w_retry_same) begin
                r_retry <= r_retry + RW'(1);
              end else begin
                r_retry <= '0;
                if (r_nack) r_ack_err <= 1'b1;
                if (!r_single) begin
                  if (r_idx == 3'd7) begin
                    r_dac         <= 1'b1;
                    r_seq_pending <= 1'b0;
                  end else begin
                    r_idx <= r_idx + 3'd1;
                  end
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_audio_codec_config.sv
// Directed bench for audio_codec_config with a WM8731-style I2C slave model
// that ACKs (or selectively NACKs) and logs every transaction's bytes.
module tb_audio_codec_config;

  logic       clk = 1'b0;
  logic       rst;
  logic       restart;
  logic [6:0] volume;
  logic       sclO;
  logic       sdaOe;
  logic       busy;
  logic       dacEn;
  logic       ackErr;
  logic       slavePull = 1'b0;
  wire        sdaLine = ~(sdaOe | slavePull);

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int nackFrom = 0;
  int nackCount = 0;
  int busErr = 0;
  int periodErr = 0;
  int startCount = 0;
  int bitPos = 0;
  int nData = 0;
  int lastRise = 0;
  int base = 0;
  logic inFrame = 1'b0;
  logic nacked = 1'b0;
  logic prevScl = 1'b1;
  logic prevSda = 1'b1;
  logic [23:0] shreg = '0;
  logic [23:0] frames[$];

  audio_codec_config #(.CLK_DIV(4), .DEV_ADDR(7'h1A), .RETRIES(2)) dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_restart(restart),
    .i_volume(volume),
    .i_sda_in(sdaLine),
    .o_scl(sclO),
    .o_sda_oe(sdaOe),
    .o_busy(busy),
    .o_dac_enable(dacEn),
    .o_ack_error(ackErr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Slave model: decodes START/STOP/bits, checks bus timing, drives ACKs
  always @(negedge clk) begin
    logic sclNow;
    logic sdaNow;
    int frameIdx;
    sclNow = sclO;
    sdaNow = sdaLine;
    if (rst) begin
      frames.delete();
      startCount = 0;
      inFrame = 1'b0;
      bitPos = 0;
      slavePull = 1'b0;
      nacked = 1'b0;
      prevScl = 1'b1;
      prevSda = 1'b1;
    end else begin
      if (prevScl && sclNow && prevSda && !sdaNow) begin
        if (inFrame) busErr++;
        inFrame = 1'b1;
        bitPos = 0;
        shreg = '0;
        nData = 0;
        nacked = 1'b0;
        startCount++;
      end else if (prevScl && sclNow && !prevSda && sdaNow) begin
        if (!inFrame || !(bitPos == 28 || (nacked && bitPos == 10))) busErr++;
        if (inFrame) frames.push_back(shreg << (24 - nData));
        inFrame = 1'b0;
      end else if (!prevScl && sclNow && inFrame) begin
        bitPos++;
        if (bitPos >= 2 && (cycle - lastRise) != 16) periodErr++;
        lastRise = cycle;
        if (bitPos <= 27 && !nacked && bitPos != 9 && bitPos != 18 && bitPos != 27) begin
          shreg = {shreg[22:0], sdaNow};
          nData++;
        end
      end else if (prevScl && !sclNow && inFrame) begin
        if (bitPos == 8 || bitPos == 17 || bitPos == 26) begin
          frameIdx = startCount - 1;
          if (bitPos == 8 && frameIdx >= nackFrom && frameIdx < nackFrom + nackCount) begin
            slavePull = 1'b0;
            nacked = 1'b1;
          end else begin
            slavePull = 1'b1;
          end
        end else begin
          slavePull = 1'b0;
        end
      end
      prevScl = sclNow;
      prevSda = sdaNow;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    restart = 1'b0;
    volume = 7'h79;
    repeat (3) @(negedge clk);
    checkOutput("rst_scl", sclO, 1);
    checkOutput("rst_sda_oe", sdaOe, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_dac", dacEn, 0);
    checkOutput("rst_ack_err", ackErr, 0);
    rst = 1'b0;

    $display("[TB] power-up sequence");
    for (int i = 0; i < 8000 && !dacEn; i++) @(negedge clk);
    checkOutput("seq_dac_rise", dacEn, 1);
    checkOutput("seq_frames_at_dac", frames.size(), 8);
    checkOutput("seq_f0", frames[0], 24'h341E00);
    checkOutput("seq_f1", frames[1], 24'h340C07);
    checkOutput("seq_f2_vol", frames[2], 24'h340579);
    checkOutput("seq_f3", frames[3], 24'h340812);
    checkOutput("seq_f5", frames[5], 24'h340E01);
    checkOutput("seq_f7", frames[7], 24'h341201);
    checkOutput("seq_ack_err", ackErr, 0);
    checkOutput("seq_busy_done", busy, 0);

    $display("[TB] volume change");
    base = frames.size();
    volume = 7'h60;
    for (int i = 0; i < 40 && !busy; i++) @(negedge clk);
    checkOutput("vol_busy", busy, 1);
    for (int i = 0; i < 1500 && busy; i++) @(negedge clk);
    checkOutput("vol_done", busy, 0);
    repeat (600) @(negedge clk);
    checkOutput("vol_count", frames.size() - base, 1);
    checkOutput("vol_frame", frames[base], 24'h340560);
    checkOutput("vol_dac_stays", dacEn, 1);

    $display("[TB] NACK on idx 3");
    nackFrom = 3;
    nackCount = 3;
    applyStimulus();
    for (int i = 0; i < 10000 && !dacEn; i++) @(negedge clk);
    checkOutput("nack_dac", dacEn, 1);
    checkOutput("nack_frames", frames.size(), 10);
    checkOutput("nack_try1", frames[3], 24'h340000);
    checkOutput("nack_try2", frames[4], 24'h340000);
    checkOutput("nack_try3", frames[5], 24'h340000);
    checkOutput("nack_next_idx4", frames[6], 24'h340A00);
    checkOutput("nack_last", frames[9], 24'h341201);
    checkOutput("nack_ack_err", ackErr, 1);
    nackCount = 0;

    $display("[TB] reset mid-transaction");
    applyStimulus();
    for (int i = 0; i < 3000 && !(startCount == 2 && bitPos >= 20); i++) @(negedge clk);
    checkOutput("mid_reached", (startCount == 2 && bitPos >= 20), 1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("mid_scl_rel", sclO, 1);
    checkOutput("mid_sda_rel", sdaOe, 0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("mid_scl_hold", sclO, 1);
    checkOutput("mid_sda_hold", sdaOe, 0);
    #1 rst = 1'b0;
    for (int i = 0; i < 6000 && !dacEn; i++) @(negedge clk);
    checkOutput("mid_dac", dacEn, 1);
    checkOutput("mid_frames", frames.size(), 8);
    checkOutput("mid_f0", frames[0], 24'h341E00);
    checkOutput("mid_f1", frames[1], 24'h340C07);
    checkOutput("mid_ack_err", ackErr, 0);

    $display("[TB] software restart");
    base = frames.size();
    checkOutput("rs_idle", busy, 0);
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("rs_dac_drop", dacEn, 0);
    checkOutput("rs_busy", busy, 1);
    for (int i = 0; i < 3000 && frames.size() < base + 3; i++) @(negedge clk);
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    for (int i = 0; i < 8000 && !dacEn; i++) @(negedge clk);
    checkOutput("rs_dac", dacEn, 1);
    checkOutput("rs_frames", frames.size() - base, 8);
    repeat (600) @(negedge clk);
    checkOutput("rs_frames_after", frames.size() - base, 8);
    checkOutput("rs_f0", frames[base], 24'h341E00);
    checkOutput("rs_idle_end", busy, 0);

    checkOutput("bus_sda_while_scl_high", busErr, 0);
    checkOutput("scl_period", periodErr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/audio_codec_config.md
Name: audio_codec_config

Overview:
Configures the board's WM8731 audio codec over I2C so that it accepts the serial stream from the audio output shifter: 16-bit, left-justified format, codec in slave mode. After reset it runs a fixed 8-register write sequence, then raises dac_enable, which releases the shifter. While idle it rewrites the headphone-volume register whenever the volume input changes. It also accepts a software restart of the full sequence.

Parameters:
CLK_DIV, 80, clk cycles per I2C quarter-bit tick (32 MHz / 80 / 4 = 100 kHz SCL); legal range >= 2
DEV_ADDR, 7'h1A, 7-bit codec I2C address
RETRIES, 2, extra attempts per register after a NACK

Ports:
clk  in  1  system clock, 32 MHz
reset  in  1  asynchronous, active-high reset
restart  in  1  one-cycle pulse; rerun the full sequence (honoured only in IDLE)
volume  in  7  headphone volume code (7'h79 = 0 dB)
sda_in  in  1  synchronised SDA pad input
scl_o  out  1  SCL; 1 = released (pulled up), 0 = driven low
sda_oe  out  1  1 = drive SDA low, 0 = release
busy  out  1  a transaction or sequence is in progress
dac_enable  out  1  codec is configured; gates the shifter's reset
ack_error  out  1  sticky; a register was skipped after all retries NACKed

Behaviour:
- Reset (async): scl_o=1, sda_oe=0, busy=0, dac_enable=0, ack_error=0, all counters 0, state=IDLE, seq_pending=1.
- Reset asserted mid-transaction: both lines are released immediately. The next START resynchronises the codec.
- Tick: a prescaler counts 0..CLK_DIV-1 and emits a one-clk tick at terminal count. All FSM and bus changes occur only on ticks.
- Register table, word = {reg[6:0], data[8:0]}, sent high byte first:
  - 0: R15=9'h000 (reset)
  - 1: R6=9'h007 (ADC/mic/line off)
  - 2: R2=9'h100|volume (both channels)
  - 3: R4=9'h012 (DAC select, mic mute)
  - 4: R5=9'h000 (DAC unmute)
  - 5: R7=9'h001 (left-justified, 16-bit, slave)
  - 6: R8=9'h000 (normal mode, 256fs)
  - 7: R9=9'h001 (active)
- Volume is latched into vol_q when a word is loaded. The index 2 word uses vol_q.
- Transaction = START, byte {DEV_ADDR,0}, ACK, high byte, ACK, low byte, ACK, STOP (27 SCL periods).
- States:
  - IDLE:
    - seq_pending: idx=0, go to START.
    - else if volume != vol_q: idx=2, single=1, go to START.
    - else if restart: set seq_pending.
    - busy=0 only in IDLE with nothing pending.
  - START: tick0 SDA low with SCL high; tick1 SCL low.
  - BIT: 4 ticks per bit.
    - q0 drive SDA (MSB first) with SCL low.
    - q1 SCL high.
    - q2 hold; on ACK slots, sample sda_in here.
    - q3 SCL low.
    - ACK slots release SDA. bitcnt counts 0..26.
  - NACK (sda_in=1 at q2 of an ACK slot): go straight to STOP, retry_cnt++.
    - retry_cnt <= RETRIES: retry the same idx.
    - else set ack_error, clear retry_cnt, advance idx.
  - STOP: q0 SDA low/SCL low, q1 SCL high, q2 SDA released. Then GAP.
  - GAP: 8 ticks with the bus idle.
    - If single: go to IDLE.
    - Else idx++. After idx 7 completes: dac_enable=1, seq_pending=0, go to IDLE.
- restart during a transaction is dropped. A volume change during a sequence is taken after the sequence ends (IDLE compare).
- dac_enable clears on reset and when a restart sequence begins. It rises only after idx 7 finishes, including when that write was skipped after NACKs.
- ack_error clears only on reset or at the start of a restart sequence.

Test Plan:
- CLK_DIV=4, codec model ACKs all bytes. Release reset -> 8 transactions on the bus; first 3 bytes 8'h34, 8'h1E, 8'h00; last 8'h34, 8'h12, 8'h01; dac_enable rises after the 8th STOP; ack_error=0.
- Same setup, volume=7'h79 at reset -> the index 2 transaction carries bytes 8'h05, 8'h79. After done, change volume to 7'h60 -> exactly one transaction 8'h34, 8'h05, 8'h60; dac_enable stays 1.
- Model NACKs the address byte of idx 3 three times -> three START..STOP attempts on R4, then idx 4 proceeds; ack_error=1; dac_enable=1 at end.
- Assert reset for 2 clks during the 2nd data byte of idx 1 -> scl_o=1 and sda_oe=0 within the reset window. After release, the sequence restarts from idx 0.
- Pulse restart in IDLE -> dac_enable drops and busy=1 on the next tick, then the full 8-register sequence repeats. A restart pulse mid-sequence is ignored (still 8 transactions total).
- Check bus timing: SDA never changes while SCL=1 except at START/STOP edges; SCL period = 4*CLK_DIV clk.
